// File: rtl/instruction_loader_if.sv
// Instruction loader bus: receive byte stream, instruction memory write port and load status.
`timescale 1ns/1ps
interface instruction_loader_if #(
   parameter int unsigned PC_BITS          = 11,
   parameter int unsigned INSTRUCTION_BITS = 32,
   parameter int unsigned BYTE_BITS        = 8
);
   logic                        i_start;
   logic [BYTE_BITS-1:0]        i_rx_data;
   logic                        i_rx_valid;
   logic                        o_rx_ready;
   logic                        o_write_inst_mem;
   logic [PC_BITS-1:0]          o_inst_mem_addr;
   logic [INSTRUCTION_BITS-1:0] o_inst_mem_data;
   logic                        o_loading;
   logic                        o_done;
   logic                        o_overflow;
   logic [PC_BITS:0]            o_inst_count;

   // Loader side
   modport master (
      input  i_start, i_rx_data, i_rx_valid,
      output o_rx_ready, o_write_inst_mem, o_inst_mem_addr, o_inst_mem_data,
      output o_loading, o_done, o_overflow, o_inst_count
   );

   // Byte source / memory / pipeline control side
   modport slave (
      output i_start, i_rx_data, i_rx_valid,
      input  o_rx_ready, o_write_inst_mem, o_inst_mem_addr, o_inst_mem_data,
      input  o_loading, o_done, o_overflow, o_inst_count
   );
endinterface

// File: rtl/instruction_loader.sv
// Assembles received bytes (big-endian) into instructions and writes them to instruction memory
// until a HALT word is written or the address space is full.
`timescale 1ns/1ps
module instruction_loader #(
   parameter int unsigned                 PC_BITS          = 11,
   parameter int unsigned                 INSTRUCTION_BITS = 32,
   parameter int unsigned                 BYTE_BITS        = 8,
   parameter logic [INSTRUCTION_BITS-1:0] HALT_INSTRUCTION = 32'hFFFFFFFF
) (
   input logic clk,
   input logic rst,
   instruction_loader_if.master bus
);
   localparam int unsigned NBYTES = INSTRUCTION_BITS / BYTE_BITS;
   localparam int unsigned BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int unsigned CW     = PC_BITS + 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RECEIVE = 2'd1,
      WRITE   = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t                      state, state_nxt;
   logic [PC_BITS-1:0]          addr, addr_nxt;
   logic [BCW-1:0]              byte_cnt, byte_cnt_nxt;
   logic [INSTRUCTION_BITS-1:0] word, word_nxt;
   logic [CW-1:0]               count, count_nxt;
   logic                        overflow, overflow_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         addr     <= '0;
         byte_cnt <= '0;
         word     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         state    <= state_nxt;
         addr     <= addr_nxt;
         byte_cnt <= byte_cnt_nxt;
         word     <= word_nxt;
         count    <= count_nxt;
         overflow <= overflow_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      addr_nxt     = addr;
      byte_cnt_nxt = byte_cnt;
      word_nxt     = word;
      count_nxt    = count;
      overflow_nxt = overflow;

      case (state)
         IDLE, DONE: begin
            if (bus.i_start) begin
               state_nxt    = RECEIVE;
               addr_nxt     = '0;
               byte_cnt_nxt = '0;
               word_nxt     = '0;
               count_nxt    = '0;
               overflow_nxt = 1'b0;
            end
         end

         RECEIVE: begin
            if (bus.i_rx_valid) begin
               // First byte received ends up in the most significant position
               word_nxt = (word << BYTE_BITS) | INSTRUCTION_BITS'(bus.i_rx_data);
               if (byte_cnt == BCW'(NBYTES - 1)) begin
                  byte_cnt_nxt = '0;
                  state_nxt    = WRITE;
               end else begin
                  byte_cnt_nxt = byte_cnt + BCW'(1);
               end
            end
         end

         WRITE: begin
            count_nxt = count + CW'(1);
            if (word == HALT_INSTRUCTION) begin
               state_nxt    = DONE;
               overflow_nxt = 1'b0;
            end else if (addr == '1) begin
               state_nxt    = DONE;
               overflow_nxt = 1'b1;
            end else begin
               addr_nxt  = addr + PC_BITS'(1);
               state_nxt = RECEIVE;
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

   // Decoded from the state register so the strobe drops with the asynchronous reset
   assign bus.o_rx_ready       = (state == RECEIVE);
   assign bus.o_write_inst_mem = (state == WRITE);
   assign bus.o_loading        = (state == RECEIVE) || (state == WRITE);
   assign bus.o_done           = (state == DONE);
   assign bus.o_inst_mem_addr  = addr;
   assign bus.o_inst_mem_data  = word;
   assign bus.o_overflow       = overflow;
   assign bus.o_inst_count     = count;
endmodule

// File: tb/tb_instruction_loader.sv
// Randomized self-checking bench for instruction_loader: a wide-address and a 2-bit-address instance.
`timescale 1ns/1ps
module tb_instruction_loader;
   localparam int unsigned PCA  = 11;
   localparam int unsigned PCB  = 2;
   localparam logic [31:0] HALT = 32'hFFFF_FFFF;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] cyc;
   } wr_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] rx_data = '0;
   logic       rx_valid = 1'b0;

   int          checks = 0;
   int          failures = 0;
   int unsigned cyc = 0;
   int unsigned accept_cyc = 0;
   int unsigned base_a = 0, base_b = 0, bad_a = 0, bad_b = 0;
   wr_t         cap_a[$];
   wr_t         cap_b[$];
   logic        prev_wr_a = 1'b0, prev_wr_b = 1'b0;

   always #5 clk = ~clk;

   instruction_loader_if #(.PC_BITS(PCA), .INSTRUCTION_BITS(32), .BYTE_BITS(8)) bus_a ();
   instruction_loader_if #(.PC_BITS(PCB), .INSTRUCTION_BITS(32), .BYTE_BITS(8)) bus_b ();

   assign bus_a.i_start    = start;
   assign bus_a.i_rx_data  = rx_data;
   assign bus_a.i_rx_valid = rx_valid;
   assign bus_b.i_start    = start;
   assign bus_b.i_rx_data  = rx_data;
   assign bus_b.i_rx_valid = rx_valid;

   instruction_loader #(.PC_BITS(PCA), .INSTRUCTION_BITS(32), .BYTE_BITS(8), .HALT_INSTRUCTION(HALT))
      dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   instruction_loader #(.PC_BITS(PCB), .INSTRUCTION_BITS(32), .BYTE_BITS(8), .HALT_INSTRUCTION(HALT))
      dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   always @(posedge clk) cyc <= cyc + 1;

   // Write monitor: logs every strobe cycle; flags strobes overlapping ready or lasting >1 cycle
   always @(negedge clk) begin
      wr_t e;
      if (bus_a.o_write_inst_mem) begin
         e.addr = 32'(bus_a.o_inst_mem_addr); e.data = bus_a.o_inst_mem_data; e.cyc = cyc;
         cap_a.push_back(e);
         if (bus_a.o_rx_ready || prev_wr_a) bad_a++;
      end
      if (bus_b.o_write_inst_mem) begin
         e.addr = 32'(bus_b.o_inst_mem_addr); e.data = bus_b.o_inst_mem_data; e.cyc = cyc;
         cap_b.push_back(e);
         if (bus_b.o_rx_ready || prev_wr_b) bad_b++;
      end
      prev_wr_a <= bus_a.o_write_inst_mem;
      prev_wr_b <= bus_b.o_write_inst_mem;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic rdy_of(input bit s);  return s ? bus_b.o_rx_ready : bus_a.o_rx_ready; endfunction
   function automatic logic done_of(input bit s); return s ? bus_b.o_done : bus_a.o_done; endfunction
   function automatic logic ovf_of(input bit s);  return s ? bus_b.o_overflow : bus_a.o_overflow; endfunction
   function automatic logic load_of(input bit s); return s ? bus_b.o_loading : bus_a.o_loading; endfunction
   function automatic int unsigned cnt_of(input bit s);
      return s ? 32'(bus_b.o_inst_count) : 32'(bus_a.o_inst_count);
   endfunction
   function automatic int unsigned cap_size(input bit s);
      return s ? (cap_b.size() - base_b) : (cap_a.size() - base_a);
   endfunction
   function automatic wr_t cap_get(input bit s, input int unsigned i);
      return s ? cap_b[base_b + i] : cap_a[base_a + i];
   endfunction
   function automatic int unsigned bad_of(input bit s); return s ? bad_b : bad_a; endfunction

   // Reference: words are written at consecutive addresses from 0 until HALT or the last address
   function automatic void model(input logic [31:0] words[$], input int unsigned pcb,
                                 output int unsigned n, output bit ovf);
      n = 0; ovf = 1'b0;
      for (int unsigned i = 0; i < words.size(); i++) begin
         n++;
         if (words[i] == HALT) break;
         if (i == (32'd1 << pcb) - 1) begin ovf = 1'b1; break; end
      end
   endfunction

   function automatic logic [31:0] rand_word();
      logic [31:0] w = $urandom;
      return (w == HALT) ? 32'h0 : w;
   endfunction

   task automatic step(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rx_valid = 1'b0; start = 1'b0;
      rst = 1'b1; #1; rst = 1'b0;
      step(2);
      rst = 1'b1;
      step(1);
      base_a = cap_a.size(); base_b = cap_b.size();
   endtask

   task automatic pulse_start();
      start = 1'b1; step(1); start = 1'b0;
   endtask

   task automatic send_byte(input bit s, input logic [7:0] b);
      bit ok = 1'b0;
      int unsigned n = 0;
      rx_valid = 1'b1; rx_data = b;
      while (!ok && n < 50) begin
         @(negedge clk); ok = rdy_of(s);
         @(posedge clk); n++;
      end
      #1;
      if (!ok) begin
         checks++; failures++;
         $display("FAIL send_byte: byte %02h not accepted within 50 cycles", b);
      end else accept_cyc = cyc;
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input bit s, input logic [31:0] w, input bit gaps);
      for (int unsigned k = 0; k < 4; k++) begin
         if (gaps) step($urandom_range(0, 2));
         send_byte(s, w[31 - 8*k -: 8]);
      end
   endtask

   task automatic test_reset();
      do_reset();
      rx_valid = 1'b1; rx_data = 8'hA5;
      step(3);
      checks++; if (bus_a.o_rx_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus_a.o_rx_ready); end
      checks++; if (bus_a.o_write_inst_mem !== 1'b0) begin failures++; $display("FAIL reset_wr got=%b exp=0", bus_a.o_write_inst_mem); end
      checks++; if (bus_a.o_loading !== 1'b0 || bus_a.o_done !== 1'b0 || bus_a.o_overflow !== 1'b0) begin
         failures++; $display("FAIL reset_status got=%b%b%b exp=000", bus_a.o_loading, bus_a.o_done, bus_a.o_overflow); end
      checks++; if (bus_a.o_inst_mem_addr !== '0 || bus_a.o_inst_mem_data !== '0 || bus_a.o_inst_count !== '0) begin
         failures++; $display("FAIL reset_regs got addr=%0h data=%h cnt=%0d exp=0", bus_a.o_inst_mem_addr, bus_a.o_inst_mem_data, bus_a.o_inst_count); end
      rx_valid = 1'b0;
   endtask

   task automatic test_single_word();
      do_reset();
      pulse_start();
      send_word(1'b0, 32'h0011_2233, 1'b0);
      step(2);
      checks++; if (cap_size(0) != 1) begin failures++; $display("FAIL single_nwr got=%0d exp=1", cap_size(0)); end
      else begin
         checks++; if (cap_get(0, 0).addr != 0 || cap_get(0, 0).data !== 32'h0011_2233) begin
            failures++; $display("FAIL single_word got=%0h:%h exp=0:00112233", cap_get(0, 0).addr, cap_get(0, 0).data); end
         checks++; if (cap_get(0, 0).cyc != accept_cyc) begin
            failures++; $display("FAIL single_latency got=%0d exp=%0d", cap_get(0, 0).cyc, accept_cyc); end
      end
      checks++; if (bus_a.o_rx_ready !== 1'b1 || bus_a.o_loading !== 1'b1 || bus_a.o_inst_count !== 12'd1) begin
         failures++; $display("FAIL single_state got rdy=%b load=%b cnt=%0d exp=1 1 1", bus_a.o_rx_ready, bus_a.o_loading, bus_a.o_inst_count); end
      checks++; if (bad_of(0) != 0) begin failures++; $display("FAIL single_strobe got=%0d exp=0", bad_of(0)); end
   endtask

   task automatic test_halt_program();
      logic [31:0] prog[3];
      prog[0] = 32'h2001_0005; prog[1] = 32'h2002_0007; prog[2] = HALT;
      do_reset();
      pulse_start();
      for (int unsigned i = 0; i < 3; i++) send_word(1'b0, prog[i], 1'b1);
      step(3);
      checks++; if (cap_size(0) != 3) begin failures++; $display("FAIL halt_nwr got=%0d exp=3", cap_size(0)); end
      else for (int unsigned i = 0; i < 3; i++) begin
         checks++; if (cap_get(0, i).addr != i || cap_get(0, i).data !== prog[i]) begin
            failures++; $display("FAIL halt_word%0d got=%0h:%h exp=%0h:%h", i, cap_get(0, i).addr, cap_get(0, i).data, i, prog[i]); end
      end
      checks++; if (bus_a.o_done !== 1'b1 || bus_a.o_overflow !== 1'b0 || bus_a.o_loading !== 1'b0) begin
         failures++; $display("FAIL halt_status got done=%b ovf=%b load=%b exp=1 0 0", bus_a.o_done, bus_a.o_overflow, bus_a.o_loading); end
      checks++; if (bus_a.o_inst_count !== 12'd3) begin failures++; $display("FAIL halt_count got=%0d exp=3", bus_a.o_inst_count); end
   endtask

   task automatic test_overflow();
      logic [31:0] prog[4];
      do_reset();
      pulse_start();
      for (int unsigned i = 0; i < 4; i++) begin prog[i] = rand_word(); send_word(1'b1, prog[i], 1'b1); end
      step(3);
      checks++; if (cap_size(1) != 4) begin failures++; $display("FAIL ovf_nwr got=%0d exp=4", cap_size(1)); end
      else for (int unsigned i = 0; i < 4; i++) begin
         checks++; if (cap_get(1, i).addr != i || cap_get(1, i).data !== prog[i]) begin
            failures++; $display("FAIL ovf_word%0d got=%0h:%h exp=%0h:%h", i, cap_get(1, i).addr, cap_get(1, i).data, i, prog[i]); end
      end
      checks++; if (bus_b.o_done !== 1'b1 || bus_b.o_overflow !== 1'b1 || bus_b.o_inst_count !== 3'd4) begin
         failures++; $display("FAIL ovf_status got done=%b ovf=%b cnt=%0d exp=1 1 4", bus_b.o_done, bus_b.o_overflow, bus_b.o_inst_count); end
      rx_valid = 1'b1; rx_data = 8'h5A;
      step(10);
      rx_valid = 1'b0;
      checks++; if (cap_size(1) != 4 || bus_b.o_rx_ready !== 1'b0) begin
         failures++; $display("FAIL ovf_no_fifth got nwr=%0d rdy=%b exp=4 0", cap_size(1), bus_b.o_rx_ready); end
   endtask

   task automatic test_write_stall();
      logic [31:0] w0, w1;
      int unsigned x_acc;
      w0 = rand_word(); w1 = rand_word();
      do_reset();
      pulse_start();
      send_word(1'b0, w0, 1'b0);
      send_byte(1'b0, w1[31:24]);
      x_acc = accept_cyc;
      send_byte(1'b0, w1[23:16]); send_byte(1'b0, w1[15:8]); send_byte(1'b0, w1[7:0]);
      step(2);
      checks++; if (cap_size(0) != 2) begin failures++; $display("FAIL stall_nwr got=%0d exp=2", cap_size(0)); end
      else begin
         checks++; if (cap_get(0, 0).data !== w0 || cap_get(0, 1).data !== w1 || cap_get(0, 1).addr != 1) begin
            failures++; $display("FAIL stall_words got=%h,%h@%0h exp=%h,%h@1", cap_get(0, 0).data, cap_get(0, 1).data, cap_get(0, 1).addr, w0, w1); end
         checks++; if (x_acc != cap_get(0, 0).cyc + 2) begin
            failures++; $display("FAIL stall_accept got=%0d exp=%0d", x_acc, cap_get(0, 0).cyc + 2); end
      end
      checks++; if (bad_of(0) != 0) begin failures++; $display("FAIL stall_ready_during_write got=%0d exp=0", bad_of(0)); end
   endtask

   task automatic test_start_ignored();
      logic [31:0] w, w2;
      w = rand_word(); w2 = rand_word();
      do_reset();
      pulse_start();
      send_byte(1'b0, w[31:24]); send_byte(1'b0, w[23:16]);
      pulse_start();
      send_byte(1'b0, w[15:8]); send_byte(1'b0, w[7:0]);
      send_word(1'b0, HALT, 1'b0);
      step(3);
      checks++; if (cap_size(0) != 2) begin failures++; $display("FAIL ign_nwr got=%0d exp=2", cap_size(0)); end
      else begin
         checks++; if (cap_get(0, 0).addr != 0 || cap_get(0, 0).data !== w || cap_get(0, 1).addr != 1) begin
            failures++; $display("FAIL ign_word got=%0h:%h exp=0:%h", cap_get(0, 0).addr, cap_get(0, 0).data, w); end
      end
      checks++; if (bus_a.o_done !== 1'b1 || bus_a.o_inst_count !== 12'd2) begin
         failures++; $display("FAIL ign_done got done=%b cnt=%0d exp=1 2", bus_a.o_done, bus_a.o_inst_count); end
      pulse_start();
      checks++; if (bus_a.o_inst_count !== '0 || bus_a.o_inst_mem_addr !== '0 || bus_a.o_done !== 1'b0 || bus_a.o_loading !== 1'b1) begin
         failures++; $display("FAIL restart_clear got cnt=%0d addr=%0h done=%b load=%b exp=0 0 0 1",
                              bus_a.o_inst_count, bus_a.o_inst_mem_addr, bus_a.o_done, bus_a.o_loading); end
      base_a = cap_a.size();
      send_word(1'b0, w2, 1'b1);
      step(2);
      checks++; if (cap_size(0) != 1 || cap_get(0, 0).addr != 0 || cap_get(0, 0).data !== w2) begin
         failures++; $display("FAIL restart_word got n=%0d exp one write 0:%h", cap_size(0), w2); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] w;
      w = rand_word();
      do_reset();
      pulse_start();
      send_byte(1'b0, 8'h81); send_byte(1'b0, 8'h42); send_byte(1'b0, 8'h24);
      #2 rst = 1'b0;
      #1;
      checks++; if (bus_a.o_rx_ready !== 1'b0 || bus_a.o_write_inst_mem !== 1'b0 || bus_a.o_loading !== 1'b0 || bus_a.o_done !== 1'b0) begin
         failures++; $display("FAIL midrst_ctrl got rdy=%b wr=%b load=%b done=%b exp=0 0 0 0",
                              bus_a.o_rx_ready, bus_a.o_write_inst_mem, bus_a.o_loading, bus_a.o_done); end
      checks++; if (bus_a.o_inst_mem_data !== '0 || bus_a.o_inst_mem_addr !== '0 || bus_a.o_inst_count !== '0) begin
         failures++; $display("FAIL midrst_regs got data=%h addr=%0h cnt=%0d exp=0", bus_a.o_inst_mem_data, bus_a.o_inst_mem_addr, bus_a.o_inst_count); end
      step(1);
      rst = 1'b1;
      step(1);
      base_a = cap_a.size();
      pulse_start();
      send_word(1'b0, w, 1'b0);
      step(2);
      checks++; if (cap_size(0) != 1 || cap_get(0, 0).addr != 0 || cap_get(0, 0).data !== w) begin
         failures++; $display("FAIL midrst_word got n=%0d exp one write 0:%h", cap_size(0), w); end
   endtask

   task automatic test_random();
      for (int unsigned it = 0; it < 8; it++) begin
         bit s = it[0];
         logic [31:0] words[$];
         int unsigned n, len;
         bit ovf;
         len = $urandom_range(1, 6);
         for (int unsigned i = 0; i < len; i++)
            words.push_back(($urandom_range(0, 7) == 0) ? HALT : rand_word());
         words.push_back(HALT);
         model(words, s ? PCB : PCA, n, ovf);
         do_reset();
         pulse_start();
         for (int unsigned i = 0; i < n; i++) send_word(s, words[i], 1'b1);
         step(3);
         checks++; if (cap_size(s) != n) begin failures++; $display("FAIL rand%0d_nwr got=%0d exp=%0d", it, cap_size(s), n); end
         else for (int unsigned i = 0; i < n; i++) begin
            checks++; if (cap_get(s, i).addr != i || cap_get(s, i).data !== words[i]) begin
               failures++; $display("FAIL rand%0d_word%0d got=%0h:%h exp=%0h:%h", it, i, cap_get(s, i).addr, cap_get(s, i).data, i, words[i]); end
         end
         checks++; if (done_of(s) !== 1'b1 || ovf_of(s) !== ovf || cnt_of(s) != n || load_of(s) !== 1'b0) begin
            failures++; $display("FAIL rand%0d_status got done=%b ovf=%b cnt=%0d exp=1 %b %0d", it, done_of(s), ovf_of(s), cnt_of(s), ovf, n); end
         checks++; if (bad_of(s) != 0) begin failures++; $display("FAIL rand%0d_strobe got=%0d exp=0", it, bad_of(s)); end
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_halt_program();
      test_overflow();
      test_write_stall();
      test_start_ignored();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
